// File: rtl/wb_regfile.sv
// Write-back register file: 32x32 GPRs plus HI/LO, committed on posedge,
// with combinational read ports that bypass the value being written this cycle.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_waddr,
  input  logic        wb_reg_we,
  input  logic [31:0] wb_data,
  input  logic        wb_hi_we,
  input  logic        wb_lo_we,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] regs_r [32];
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // GPR array update; r0 is never written so it stays at its reset value of 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (wb_reg_we && (wb_waddr != 5'd0)) begin
        regs_r[wb_waddr] <= wb_data;
      end
    end
  end

  // HI/LO update, enables independent of each other
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= 32'h0000_0000;
      lo_r <= 32'h0000_0000;
    end else begin
      if (wb_hi_we) begin
        hi_r <= wb_hi;
      end
      if (wb_lo_we) begin
        lo_r <= wb_lo;
      end
    end
  end

  // Read port 1 with write-to-read bypass
  always_comb begin
    rdata1 = 32'h0000_0000;
    if (rst) begin
      rdata1 = 32'h0000_0000;
    end else if (raddr1 == 5'd0) begin
      rdata1 = 32'h0000_0000;
    end else if (!re1) begin
      rdata1 = 32'h0000_0000;
    end else if (wb_reg_we && (wb_waddr == raddr1)) begin
      rdata1 = wb_data;
    end else begin
      rdata1 = regs_r[raddr1];
    end
  end

  // Read port 2 with write-to-read bypass
  always_comb begin
    rdata2 = 32'h0000_0000;
    if (rst) begin
      rdata2 = 32'h0000_0000;
    end else if (raddr2 == 5'd0) begin
      rdata2 = 32'h0000_0000;
    end else if (!re2) begin
      rdata2 = 32'h0000_0000;
    end else if (wb_reg_we && (wb_waddr == raddr2)) begin
      rdata2 = wb_data;
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end

  // HI/LO outputs with bypass of the pending write
  always_comb begin
    hi_o = 32'h0000_0000;
    lo_o = 32'h0000_0000;
    if (rst) begin
      hi_o = 32'h0000_0000;
      lo_o = 32'h0000_0000;
    end else begin
      if (wb_hi_we) begin
        hi_o = wb_hi;
      end else begin
        hi_o = hi_r;
      end
      if (wb_lo_we) begin
        lo_o = wb_lo;
      end else begin
        lo_o = lo_r;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios then randomized traffic
// compared against an array-based reference model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_waddr;
  logic        wb_reg_we;
  logic [31:0] wb_data;
  logic        wb_hi_we;
  logic        wb_lo_we;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int fails = 0;

  logic [31:0] model [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_waddr(wb_waddr), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
    .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (rst || a == 5'd0 || !en) return 32'h0;
    if (wb_reg_we && wb_waddr == a) return wb_data;
    return model[a];
  endfunction

  function automatic logic [31:0] exp_hi();
    if (rst) return 32'h0;
    return wb_hi_we ? wb_hi : m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (rst) return 32'h0;
    return wb_lo_we ? wb_lo : m_lo;
  endfunction

  // Compare all outputs to the model, clock one edge, then apply the edge to the model.
  task automatic step();
    chk("rdata1", rdata1, exp_rd(re1, raddr1));
    chk("rdata2", rdata2, exp_rd(re2, raddr2));
    chk("hi_o", hi_o, exp_hi());
    chk("lo_o", lo_o, exp_lo());
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (wb_reg_we && wb_waddr != 5'd0) model[wb_waddr] = wb_data;
      if (wb_hi_we) m_hi = wb_hi;
      if (wb_lo_we) m_lo = wb_lo;
    end
    #1;
  endtask

  task automatic idle();
    wb_reg_we = 1'b0; wb_hi_we = 1'b0; wb_lo_we = 1'b0;
    wb_waddr = 5'd0; wb_data = 32'h0; wb_hi = 32'h0; wb_lo = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    idle();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;

    // Preload r5 and hi, then reset with a read pending
    wb_reg_we = 1'b1; wb_waddr = 5'd5; wb_data = 32'hDEAD_BEEF;
    wb_hi_we = 1'b1; wb_hi = 32'h0000_1234;
    #1; step();
    idle(); re1 = 1'b1; raddr1 = 5'd5;
    #1; chk("preload_r5", rdata1, 32'hDEAD_BEEF); chk("preload_hi", hi_o, 32'h0000_1234);
    step();
    rst = 1'b1;
    #1; chk("rst_during_r5", rdata1, 32'h0); chk("rst_during_hi", hi_o, 32'h0);
    step();
    rst = 1'b0;
    #1; chk("rst_after_r5", rdata1, 32'h0); chk("rst_after_hi", hi_o, 32'h0);
    step();

    // Write then read back on both ports, then disable port 2
    idle(); wb_reg_we = 1'b1; wb_waddr = 5'd7; wb_data = 32'hA5A5_A5A5;
    #1; step();
    idle(); re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1; chk("rb_p1", rdata1, 32'hA5A5_A5A5); chk("rb_p2", rdata2, 32'hA5A5_A5A5);
    step();
    re2 = 1'b0;
    #1; chk("rb_p2_dis", rdata2, 32'h0);
    step();

    // r0 protection including bypass condition
    idle(); wb_reg_we = 1'b1; wb_waddr = 5'd0; wb_data = 32'hFFFF_FFFF; re1 = 1'b1; raddr1 = 5'd0;
    #1; chk("r0_bypass", rdata1, 32'h0);
    step();
    wb_reg_we = 1'b0;
    #1; chk("r0_after", rdata1, 32'h0);
    step();

    // Bypass of new value over stored value
    idle(); wb_reg_we = 1'b1; wb_waddr = 5'd3; wb_data = 32'h0000_0011;
    #1; step();
    wb_data = 32'h0000_0022; re1 = 1'b1; raddr1 = 5'd3;
    #1; chk("bypass_same", rdata1, 32'h0000_0022);
    step();
    wb_reg_we = 1'b0;
    #1; chk("bypass_next", rdata1, 32'h0000_0022);
    step();

    // HI/LO independent and joint writes
    idle(); wb_hi_we = 1'b1; wb_hi = 32'hCAFE_BABE; wb_lo = 32'h7777_7777;
    #1; chk("hi_bypass", hi_o, 32'hCAFE_BABE); chk("lo_unchanged", lo_o, 32'h0);
    step();
    wb_lo_we = 1'b1; wb_hi = 32'h0000_0001; wb_lo = 32'h0000_0002;
    #1; step();
    idle();
    #1; chk("hi_both", hi_o, 32'h0000_0001); chk("lo_both", lo_o, 32'h0000_0002);
    step();

    // Write coinciding with reset is lost
    rst = 1'b1; wb_reg_we = 1'b1; wb_waddr = 5'd9; wb_data = 32'h0000_0055;
    #1; step();
    rst = 1'b0; idle(); re1 = 1'b1; raddr1 = 5'd9;
    #1; chk("rst_write_lost", rdata1, 32'h0);
    step();

    // Randomized traffic; addresses biased to a small range to force collisions
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      wb_reg_we = $urandom_range(0, 1);
      wb_waddr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      wb_hi_we  = $urandom_range(0, 1);
      wb_lo_we  = $urandom_range(0, 1);
      wb_hi     = $urandom;
      wb_lo     = $urandom;
      re1       = ($urandom_range(0, 3) != 0);
      re2       = ($urandom_range(0, 3) != 0);
      raddr1    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      raddr2    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      #1; step();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
